// File: rtl/spi_slave_regif_pkg.sv
// rtl/spi_slave_regif_pkg.sv - shared frame constants, FSM state encoding and helpers for the SPI slave
package spi_slave_regif_pkg;

    localparam int SPI_FRAME_BITS = 48;
    localparam int SPI_HDR_BITS   = 16;
    localparam int SPI_DATA_BITS  = 32;

    localparam logic [14:0] SPI_ERR_CLR_ADDR = 15'h7FFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_RDWAIT = 3'd2,
        ST_RDATA  = 3'd3,
        ST_WDATA  = 3'd4,
        ST_DONE   = 3'd5
    } spi_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/spi_slave_regif_if.sv
// rtl/spi_slave_regif_if.sv - register-side bus between the SPI slave and the register blocks
interface spi_slave_regif_if;
    import spi_slave_regif_pkg::*;

    logic [15:0]              addr;
    logic [SPI_DATA_BITS-1:0] data_mosi;
    logic                     data_mosi_rdy;
    logic                     rd_req;
    logic [SPI_DATA_BITS-1:0] rd_data;

    modport master (
        output addr,
        output data_mosi,
        output data_mosi_rdy,
        output rd_req,
        input  rd_data
    );

    modport slave (
        input  addr,
        input  data_mosi,
        input  data_mosi_rdy,
        input  rd_req,
        output rd_data
    );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall detection on the synchronized level
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // Shift the raw input through the chain; keep one delayed copy of the synchronized level
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    // Synchronizer and edge-history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_slave_regif.sv
// rtl/spi_slave_regif.sv - SPI mode-0 slave turning 48-bit frames into register writes/reads (optional: SPI_ERR_CNT_EN)
module spi_slave_regif
    import spi_slave_regif_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RD_LATENCY  = 1
) (
    input  logic                      clk_100m,
    input  logic                      rst_n_syn,
    input  logic                      spi_sclk,
    input  logic                      spi_cs_n,
    input  logic                      spi_mosi,
    output logic                      spi_miso,
    spi_slave_regif_if.master         bus,
    output logic [15:0]               spi_err_cnt
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk   (clk_100m),
        .rst_n (rst_n_syn),
        .din   (spi_sclk),
        .dout  (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk   (clk_100m),
        .rst_n (rst_n_syn),
        .din   (spi_cs_n),
        .dout  (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk   (clk_100m),
        .rst_n (rst_n_syn),
        .din   (spi_mosi),
        .dout  (mosi_s),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    // Only edges of sclk/cs_n and the level of mosi drive the FSM
    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

    spi_state_e                state_q, state_d;
    logic [4:0]                bit_cnt_q, bit_cnt_d;
    logic [30:0]               rx_q, rx_d;
    logic [30:0]               tx_q, tx_d;
    logic [1:0]                wait_q, wait_d;
    logic                      miso_q, miso_d;
    logic [15:0]               addr_q, addr_d;
    logic [SPI_DATA_BITS-1:0]  data_q, data_d;
    logic                      rdy_q, rdy_d;
    logic                      rd_req_q, rd_req_d;
    logic [SYNC_STAGES:0]      arm_q, arm_d;
    logic [31:0]               rx_shift;
    logic                      armed;
    logic                      abort;

    // The cs_n synchronizer resets high, so a low cs_n at reset release looks like a fall;
    // hold off frame starts until the chain holds real samples so such a frame is ignored
    assign armed = arm_q[SYNC_STAGES];
    assign rx_shift = {rx_q, mosi_s};

    // Frame sequencing: header collection, read fetch/shift-out, write collection, abort
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        wait_d    = wait_q;
        miso_d    = miso_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rdy_d     = 1'b0;
        rd_req_d  = 1'b0;
        arm_d     = {arm_q[SYNC_STAGES-1:0], 1'b1};
        abort     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall && armed) begin
                    bit_cnt_d = '0;
                    state_d   = ST_HDR;
                end
            end
            ST_HDR: begin
                if (cs_rise) begin
                    abort = 1'b1;
                end else if (sclk_rise) begin
                    rx_d = rx_shift[30:0];
                    if (bit_cnt_q == 5'(SPI_HDR_BITS - 1)) begin
                        addr_d    = {1'b0, rx_shift[14:0]};
                        bit_cnt_d = '0;
                        if (rx_shift[15]) begin
                            rd_req_d = 1'b1;
                            wait_d   = '0;
                            state_d  = ST_RDWAIT;
                        end else begin
                            state_d  = ST_WDATA;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            ST_RDWAIT: begin
                if (cs_rise) begin
                    abort = 1'b1;
                end else if (wait_q == 2'(RD_LATENCY)) begin
                    tx_d    = bus.rd_data[30:0];
                    miso_d  = bus.rd_data[31];
                    state_d = ST_RDATA;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_RDATA: begin
                if (cs_rise) begin
                    abort = 1'b1;
                end else begin
                    // The fall closing the header's last bit must not shift: bit 31 is already out
                    if (sclk_fall && (bit_cnt_q != '0)) begin
                        miso_d = tx_q[30];
                        tx_d   = {tx_q[29:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        if (bit_cnt_q == 5'(SPI_DATA_BITS - 1)) begin
                            state_d = ST_DONE;
                        end
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            ST_WDATA: begin
                if (cs_rise) begin
                    abort = 1'b1;
                end else if (sclk_rise) begin
                    rx_d = rx_shift[30:0];
                    if (bit_cnt_q == 5'(SPI_DATA_BITS - 1)) begin
                        data_d  = rx_shift;
                        rdy_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            ST_DONE: begin
                if (cs_rise) begin
                    miso_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            miso_d  = 1'b0;
            state_d = ST_IDLE;
        end
    end

    // FSM, shift registers and register-bus outputs
    always_ff @(posedge clk_100m or negedge rst_n_syn) begin
        if (!rst_n_syn) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            wait_q    <= '0;
            miso_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rdy_q     <= 1'b0;
            rd_req_q  <= 1'b0;
            arm_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            wait_q    <= wait_d;
            miso_q    <= miso_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            rd_req_q  <= rd_req_d;
            arm_q     <= arm_d;
        end
    end

`ifdef SPI_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_clr;

    assign err_clr = rdy_d & (addr_q[14:0] == SPI_ERR_CLR_ADDR);

    // Saturating aborted-frame count; a completed write to the clear address zeroes it
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (abort) begin
            err_cnt_d = sat_inc16(err_cnt_q);
        end
    end

    // Error counter register
    always_ff @(posedge clk_100m or negedge rst_n_syn) begin
        if (!rst_n_syn) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign spi_err_cnt = err_cnt_q;
`else
    assign spi_err_cnt = '0;
`endif

    assign spi_miso          = miso_q;
    assign bus.addr          = addr_q;
    assign bus.data_mosi     = data_q;
    assign bus.data_mosi_rdy = rdy_q;
    assign bus.rd_req        = rd_req_q;

endmodule

// File: tb/tb_spi_slave_regif.sv
// tb/tb_spi_slave_regif.sv - self-checking bench for spi_slave_regif with a frame-level reference model
module tb_spi_slave_regif;

    localparam int HALF = 10;

    logic        clk_100m = 1'b0;
    logic        rst_n_syn;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [15:0] spi_err_cnt;

    spi_slave_regif_if bus();

    spi_slave_regif #(.SYNC_STAGES(2), .RD_LATENCY(1)) dut (
        .clk_100m    (clk_100m),
        .rst_n_syn   (rst_n_syn),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .bus         (bus),
        .spi_err_cnt (spi_err_cnt)
    );

    always #5 clk_100m = ~clk_100m;

    int n_cmp = 0;
    int n_mis = 0;

    int          rdy_cnt = 0;
    int          rdreq_cnt = 0;
    int          both_cnt = 0;
    logic [15:0] rdy_addr = '0;
    logic [31:0] rdy_data = '0;
    logic [15:0] rdreq_addr = '0;
    logic [31:0] rd_val = '0;
    bit          rd_pend = 1'b0;

    logic [15:0] m_addr = '0;
    logic [31:0] m_data = '0;
    logic [15:0] m_err = '0;

    task automatic check_val(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register-side monitor plus read-mux model: rd_data is valid exactly one cycle after rd_req
    initial begin
        forever begin
            @(negedge clk_100m);
            if (bus.data_mosi_rdy === 1'b1) begin
                rdy_cnt++;
                rdy_addr = bus.addr;
                rdy_data = bus.data_mosi;
            end
            if (bus.rd_req === 1'b1) begin
                rdreq_cnt++;
                rdreq_addr = bus.addr;
            end
            if (bus.rd_req === 1'b1 && bus.data_mosi_rdy === 1'b1) both_cnt++;
            bus.rd_data = rd_pend ? rd_val : ~rd_val;
            rd_pend = (bus.rd_req === 1'b1);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_100m);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        wait_clk(HALF);
        spi_cs_n = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic sclk_bit(input logic b, output logic m);
        spi_mosi = b;
        wait_clk(HALF);
        spi_sclk = 1'b1;
        m = spi_miso;
        wait_clk(HALF);
        spi_sclk = 1'b0;
    endtask

    function automatic logic [15:0] err_next(input logic [15:0] e, input bit rw, input logic [14:0] a, input int nbits);
        if (nbits < 48) return (e == 16'hFFFF) ? e : e + 16'd1;
        if (!rw && a == 15'h7FFF) return 16'h0000;
        return e;
    endfunction

    task automatic run_frame(input bit rw, input logic [14:0] a, input logic [31:0] d,
                             input int nbits, input int extra);
        logic [47:0] fr;
        logic [31:0] cap;
        logic        m;
        int          r0, q0;
        fr  = {rw, a, d};
        r0  = rdy_cnt;
        q0  = rdreq_cnt;
        cap = '0;
        cs_low();
        for (int i = 0; i < nbits; i++) begin
            sclk_bit(fr[47-i], m);
            if (i >= 16) cap = {cap[30:0], m};
        end
        for (int i = 0; i < extra; i++) sclk_bit(1'($urandom), m);
        cs_high();

        if (nbits >= 16) m_addr = {1'b0, a};
        if (!rw && nbits >= 48) m_data = d;
        m_err = err_next(m_err, rw, a, nbits);

        check_val("rdy_pulses", 48'(rdy_cnt - r0), 48'((!rw && nbits >= 48) ? 1 : 0));
        check_val("rdreq_pulses", 48'(rdreq_cnt - q0), 48'((rw && nbits >= 16) ? 1 : 0));
        if (!rw && nbits >= 48) begin
            check_val("strobe_addr", 48'(rdy_addr), 48'({1'b0, a}));
            check_val("strobe_data", 48'(rdy_data), 48'(d));
        end
        if (rw && nbits >= 16) check_val("rdreq_addr", 48'(rdreq_addr), 48'({1'b0, a}));
        if (rw && nbits >= 48) check_val("miso_word", 48'(cap), 48'(rd_val));
        check_val("addr_hold", 48'(bus.addr), 48'(m_addr));
        check_val("data_hold", 48'(bus.data_mosi), 48'(m_data));
        check_val("miso_idle", 48'(spi_miso), 48'(0));
`ifdef SPI_ERR_CNT_EN
        check_val("err_cnt", 48'(spi_err_cnt), 48'(m_err));
`else
        check_val("err_cnt", 48'(spi_err_cnt), 48'(0));
`endif
        check_val("no_overlap", 48'(both_cnt), 48'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_addr"}, 48'(bus.addr), 48'(0));
        check_val({tag, "_data"}, 48'(bus.data_mosi), 48'(0));
        check_val({tag, "_rdy"}, 48'(bus.data_mosi_rdy), 48'(0));
        check_val({tag, "_rdreq"}, 48'(bus.rd_req), 48'(0));
        check_val({tag, "_miso"}, 48'(spi_miso), 48'(0));
        check_val({tag, "_err"}, 48'(spi_err_cnt), 48'(0));
    endtask

    task automatic reset_mid_read();
        logic [47:0] fr;
        logic        m;
        int          r0, q0;
        rd_val = $urandom;
        fr = {1'b1, 15'h0033, 32'h0};
        cs_low();
        for (int i = 0; i < 30; i++) sclk_bit(fr[47-i], m);
        rst_n_syn = 1'b0;
        wait_clk(3);
        check_reset_outputs("midrst");
        m_addr = '0;
        m_data = '0;
        m_err  = '0;
        rst_n_syn = 1'b1;
        r0 = rdy_cnt;
        q0 = rdreq_cnt;
        fr = {1'b1, 15'h0044, 32'hFFFF_FFFF};
        for (int i = 0; i < 18; i++) sclk_bit(fr[47-i], m);
        cs_high();
        check_val("postrst_rdy", 48'(rdy_cnt - r0), 48'(0));
        check_val("postrst_rdreq", 48'(rdreq_cnt - q0), 48'(0));
        check_val("postrst_addr", 48'(bus.addr), 48'(0));
        check_val("postrst_err", 48'(spi_err_cnt), 48'(0));
    endtask

    initial begin
        bit          rw;
        logic [14:0] a;
        int          nb;
        spi_sclk  = 1'b0;
        spi_cs_n  = 1'b1;
        spi_mosi  = 1'b0;
        rst_n_syn = 1'b0;
        bus.rd_data = '0;
        wait_clk(5);
        check_reset_outputs("reset");
        rst_n_syn = 1'b1;
        wait_clk(10);

        run_frame(1'b0, 15'h0004, 32'h00A5_5A01, 48, 0);
        rd_val = 32'h8000_1234;
        run_frame(1'b1, 15'h0006, 32'h0, 48, 0);
        run_frame(1'b0, 15'h0011, $urandom, 20, 0);
        run_frame(1'b0, 15'h0012, 32'hDEAD_BEEF, 48, 0);
        run_frame(1'b0, 15'h0020, 32'h1234_5678, 48, 8);

        reset_mid_read();
        run_frame(1'b0, 15'h0021, 32'h0000_0001, 48, 0);

        for (int i = 0; i < 5; i++) begin
            rw = 1'($urandom);
            rd_val = $urandom;
            run_frame(rw, 15'($urandom), $urandom, $urandom_range(0, 47), 0);
        end
        run_frame(1'b0, 15'h7FFF, $urandom, 48, 0);

        for (int i = 0; i < 16; i++) begin
            rw = 1'($urandom);
            a  = 15'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 47) : 48;
            rd_val = $urandom;
            run_frame(rw, a, $urandom, nb, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
